if_stage: RTL and testbench

IF_STAGE -- requirements
Module: if_stage

---
 rtl/if_stage.sv | 123 ++++++++++++
 tb/tb_if_stage.sv | 238 +++++++++++++++++++++++
 2 files changed

// File: rtl/if_stage.sv
// Instruction fetch stage: issues sequential reads to a one-cycle-latency
// instruction memory, buffers returned words in a 2-entry FIFO and hands them
// to decode under a valid/ready handshake. A redirect flushes the stream.
module if_stage #(
    parameter int                   WORD_SIZE = 32,
    parameter int                   ADDR_SIZE = 10,
    parameter logic [ADDR_SIZE-1:0] RESET_PC  = '0
) (
    input  logic                 clk,
    input  logic                 rst_n,
    output logic                 imem_en,
    output logic [ADDR_SIZE-1:0] imem_addr,
    input  logic [WORD_SIZE-1:0] imem_rdata,
    input  logic                 redirect,
    input  logic [ADDR_SIZE-1:0] redirect_pc,
    input  logic                 id_ready,
    output logic                 instr_valid,
    output logic [WORD_SIZE-1:0] instr,
    output logic [ADDR_SIZE-1:0] pc
);

    localparam logic [WORD_SIZE-1:0] NOP = WORD_SIZE'(32'h0000_0013);

    logic [ADDR_SIZE-1:0] fpc;
    logic                 inflight;
    logic [ADDR_SIZE-1:0] inflight_addr;

    logic [1:0]           count;
    logic [ADDR_SIZE-1:0] head_pc;
    logic [WORD_SIZE-1:0] head_instr;
    logic [ADDR_SIZE-1:0] tail_pc;
    logic [WORD_SIZE-1:0] tail_instr;

    logic                 pop;
    logic                 push;
    logic [2:0]           occ;

    // Handshake and issue decision: a read may only be issued if the FIFO
    // is guaranteed to have room for it when the data returns next cycle.
    always_comb begin
        pop         = instr_valid & id_ready;
        push        = inflight & ~redirect;
        occ         = 3'(count) + 3'(inflight) - 3'(pop);
        imem_en     = rst_n & ~redirect & (occ < 3'd2);
        imem_addr   = fpc;
        instr_valid = (count != 2'd0);
        instr       = instr_valid ? head_instr : NOP;
        pc          = head_pc;
    end

    // Fetch pointer: redirect wins, otherwise advance by one word per issue.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fpc <= RESET_PC;
        end else if (redirect) begin
            fpc <= redirect_pc;
        end else if (imem_en) begin
            fpc <= fpc + ADDR_SIZE'(4);
        end
    end

    // In-flight tracker: exactly mirrors last cycle's issue, so a redirect
    // (which forces imem_en low) drops whatever response is still pending.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            inflight      <= 1'b0;
            inflight_addr <= RESET_PC;
        end else begin
            inflight <= imem_en;
            if (imem_en) begin
                inflight_addr <= fpc;
            end
        end
    end

    // 2-entry FIFO with a fixed head slot. When the last entry is popped the
    // head is left untouched so pc keeps showing the last delivered address.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count      <= 2'd0;
            head_pc    <= RESET_PC;
            head_instr <= '0;
            tail_pc    <= '0;
            tail_instr <= '0;
        end else if (redirect) begin
            count <= 2'd0;
        end else begin
            case ({push, pop})
                2'b10: begin
                    if (count == 2'd0) begin
                        head_pc    <= inflight_addr;
                        head_instr <= imem_rdata;
                    end else begin
                        tail_pc    <= inflight_addr;
                        tail_instr <= imem_rdata;
                    end
                    count <= count + 2'd1;
                end
                2'b01: begin
                    if (count == 2'd2) begin
                        head_pc    <= tail_pc;
                        head_instr <= tail_instr;
                    end
                    count <= count - 2'd1;
                end
                2'b11: begin
                    if (count == 2'd1) begin
                        head_pc    <= inflight_addr;
                        head_instr <= imem_rdata;
                    end else begin
                        head_pc    <= tail_pc;
                        head_instr <= tail_instr;
                        tail_pc    <= inflight_addr;
                        tail_instr <= imem_rdata;
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_if_stage.sv
// Directed bench for if_stage: a scoreboard queue of expected pcs is filled by
// the stimulus, and a negedge monitor pops and checks every accepted transfer.
module tb_if_stage;

    localparam int W = 32;
    localparam int A = 10;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         imem_en;
    logic [A-1:0] imem_addr;
    logic [W-1:0] imem_rdata = '0;
    logic         redirect = 1'b0;
    logic [A-1:0] redirect_pc = '0;
    logic         id_ready = 1'b0;
    logic         instr_valid;
    logic [W-1:0] instr;
    logic [A-1:0] pc;

    int vectors = 0;
    int miscompares = 0;
    logic [A-1:0] exp_q[$];

    logic         have_prev = 1'b0;
    logic [A-1:0] prev_pc;
    logic [W-1:0] prev_instr;

    if_stage #(.WORD_SIZE(W), .ADDR_SIZE(A), .RESET_PC('0)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .imem_en     (imem_en),
        .imem_addr   (imem_addr),
        .imem_rdata  (imem_rdata),
        .redirect    (redirect),
        .redirect_pc (redirect_pc),
        .id_ready    (id_ready),
        .instr_valid (instr_valid),
        .instr       (instr),
        .pc          (pc)
    );

    always #5 clk = ~clk;

    // Memory model: word i holds 0x1000+i, one-cycle read latency.
    always @(posedge clk) begin
        if (imem_en) imem_rdata <= 32'h1000 + 32'(imem_addr >> 2);
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Monitor: checks accepted transfers against the scoreboard, stall stability
    // and the FIFO overflow condition.
    always @(negedge clk) begin
        logic [A-1:0] e;
        if (!rst_n) begin
            have_prev = 1'b0;
        end else begin
            if (have_prev) begin
                check("stall_valid", instr_valid, 1);
                check("stall_pc", pc, prev_pc);
                check("stall_instr", instr, prev_instr);
            end
            if (instr_valid && id_ready && !redirect) begin
                if (exp_q.size() == 0) begin
                    vectors++;
                    miscompares++;
                    $display("FAIL unexpected_out: got pc %h expected none", pc);
                end else begin
                    e = exp_q.pop_front();
                    check("sb_pc", pc, e);
                    check("sb_instr", instr, 32'h1000 + 32'(e >> 2));
                end
            end
            if (dut.count == 2'd2 && dut.inflight && !redirect && !(instr_valid && id_ready)) begin
                miscompares++;
                $display("FAIL overflow: got push into full fifo expected none");
            end
            have_prev  = instr_valid && !id_ready && !redirect;
            prev_pc    = pc;
            prev_instr = instr;
        end
    end

    task automatic nxt();
        @(posedge clk);
        #1;
    endtask

    // Ends the previous phase, checks reset values, releases reset so the
    // caller resumes at posedge+1 of cycle 0.
    task automatic do_reset();
        id_ready = 1'b0;
        redirect = 1'b0;
        check("leftover_expected", exp_q.size(), 0);
        exp_q.delete();
        #2 rst_n = 1'b0;
        #1;
        check("rst_en", imem_en, 0);
        check("rst_valid", instr_valid, 0);
        check("rst_instr", instr, 32'h13);
        check("rst_pc", pc, 0);
        repeat (2) @(posedge clk);
        nxt();
        rst_n = 1'b1;
    endtask

    initial begin
        // Streaming plus a 4-cycle stall.
        do_reset();
        for (int i = 0; i < 10; i++) exp_q.push_back(A'(4 * i));
        for (int c = 0; c < 16; c++) begin
            id_ready = !(c >= 6 && c <= 9);
            @(negedge clk);
            if (c < 4) begin
                check("stream_en", imem_en, 1);
                check("stream_addr", imem_addr, 32'(4 * c));
            end
            if (c == 1) begin
                check("valid_c1", instr_valid, 0);
                check("nop_idle", instr, 32'h13);
                check("pc_idle", pc, 0);
            end
            if (c == 2) check("valid_c2", instr_valid, 1);
            if (c == 8) check("en_full", imem_en, 0);
            if (c == 10) begin
                check("en_resume", imem_en, 1);
                check("addr_resume", imem_addr, 32'h18);
            end
            nxt();
        end

        // Redirect with a full FIFO.
        do_reset();
        foreach (exp_q[i]) ;
        exp_q.push_back(A'(0));     exp_q.push_back(A'(4));
        exp_q.push_back(A'(8));     exp_q.push_back(A'(12));
        exp_q.push_back(A'(10'h100)); exp_q.push_back(A'(10'h104));
        exp_q.push_back(A'(10'h108)); exp_q.push_back(A'(10'h10C));
        for (int c = 0; c < 14; c++) begin
            id_ready    = (c <= 5) || (c >= 8);
            redirect    = (c == 7);
            redirect_pc = A'(10'h100);
            @(negedge clk);
            if (c == 6) check("full_en_c6", imem_en, 0);
            if (c == 7) check("redir_en", imem_en, 0);
            if (c == 8) begin
                check("redir_issue_en", imem_en, 1);
                check("redir_issue_addr", imem_addr, 32'h100);
                check("flushed_c8", instr_valid, 0);
            end
            if (c == 9) check("flushed_c9", instr_valid, 0);
            if (c == 10) begin
                check("redir_valid", instr_valid, 1);
                check("redir_pc", pc, 32'h100);
            end
            nxt();
        end

        // Redirect coincident with pop, then back-to-back redirect.
        do_reset();
        exp_q.push_back(A'(0));  exp_q.push_back(A'(4));
        exp_q.push_back(A'(10'h80)); exp_q.push_back(A'(10'h84)); exp_q.push_back(A'(10'h88));
        for (int c = 0; c < 11; c++) begin
            id_ready    = 1'b1;
            redirect    = (c == 4) || (c == 5);
            redirect_pc = (c == 4) ? A'(10'h40) : A'(10'h80);
            @(negedge clk);
            if (c == 5) begin
                check("b2b_en", imem_en, 0);
                check("b2b_flushed", instr_valid, 0);
            end
            if (c == 6) begin
                check("b2b_issue_en", imem_en, 1);
                check("b2b_issue_addr", imem_addr, 32'h80);
            end
            if (c == 7) check("b2b_valid_c7", instr_valid, 0);
            nxt();
        end

        // Address wrap at the top of the space.
        do_reset();
        exp_q.push_back(A'(10'h3F8)); exp_q.push_back(A'(10'h3FC));
        exp_q.push_back(A'(0));       exp_q.push_back(A'(4));
        for (int c = 0; c < 7; c++) begin
            id_ready    = 1'b1;
            redirect    = (c == 0);
            redirect_pc = A'(10'h3F8);
            @(negedge clk);
            if (c == 2) check("wrap_addr_3fc", imem_addr, 32'h3FC);
            if (c == 3) begin
                check("wrap_en", imem_en, 1);
                check("wrap_addr_0", imem_addr, 32'h0);
            end
            nxt();
        end

        // Asynchronous reset mid-stream.
        do_reset();
        for (int i = 0; i < 4; i++) exp_q.push_back(A'(4 * i));
        for (int i = 0; i < 3; i++) exp_q.push_back(A'(4 * i));
        for (int c = 0; c < 6; c++) begin
            id_ready = 1'b1;
            nxt();
        end
        id_ready = 1'b0;
        check("pre_areset_valid", instr_valid, 1);
        #1 rst_n = 1'b0;
        #1;
        check("areset_valid", instr_valid, 0);
        check("areset_en", imem_en, 0);
        check("areset_instr", instr, 32'h13);
        check("areset_pc", pc, 0);
        #1 rst_n = 1'b1;
        @(negedge clk);
        check("rerun_en", imem_en, 1);
        check("rerun_addr", imem_addr, 32'h0);
        nxt();
        for (int c = 1; c < 6; c++) begin
            id_ready = (c <= 4);
            @(negedge clk);
            if (c == 1) check("rerun_valid_c1", instr_valid, 0);
            if (c == 2) check("rerun_valid_c2", instr_valid, 1);
            nxt();
        end

        id_ready = 1'b0;
        check("final_leftover", exp_q.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
